// File: rtl/ir_pkg.sv
// Shared definitions for the NEC IR encoder.
// Holds the frame state encoding, the NEC unit counts for each frame
// section, the payload width and the unit-length helper used to derive
// cycle counts from the clock frequency.
package ir_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LEAD_MARK,
    LEAD_SPACE,
    BIT_MARK,
    BIT_SPACE,
    STOP_MARK,
    GAP
  } ir_state_t;

  localparam int unsigned NEC_BITS = 32;

  // Section lengths in 562.5 us units
  localparam int unsigned LEAD_MARK_UNITS    = 16;
  localparam int unsigned LEAD_SPACE_UNITS   = 8;
  localparam int unsigned REPEAT_SPACE_UNITS = 4;
  localparam int unsigned ONE_SPACE_UNITS    = 3;
  localparam int unsigned SHORT_UNITS        = 1;

  // One NEC unit is 9/16 ms; widened so large clock rates do not overflow
  function automatic int unsigned unit_cycles_f(input int unsigned clk_hz);
    longint unsigned prod;
    prod = longint'(clk_hz) * 9;
    return int'(prod / 16000);
  endfunction

endpackage

// File: rtl/ir_carrier.sv
// IR carrier generator.
// Produces a square wave that toggles every half_cycles clocks. A restart
// pulse forces the wave high with a fresh half period on the next cycle, so
// every mark begins with a full high half period.
//   clk      : system clock
//   rst      : synchronous active-high reset (carrier low)
//   restart  : realign the carrier to start high on the next cycle
//   carrier  : carrier square wave
module ir_carrier #(
  parameter int unsigned half_cycles = 328
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic carrier
);

  localparam int unsigned CNT_W = (half_cycles > 1) ? $clog2(half_cycles) : 1;

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= '0;
      carrier <= 1'b0;
    end else if (restart) begin
      cnt     <= '0;
      carrier <= 1'b1;
    end else if (cnt == CNT_W'(half_cycles - 1)) begin
      cnt     <= '0;
      carrier <= ~carrier;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/ir_encoder.sv
// NEC infrared transmitter.
// Accepts a full-frame request (start) or a repeat-code request (repeat_req)
// while idle and emits the NEC mark/space envelope followed by a guard gap.
//   clk        : system clock
//   rst        : synchronous active-high reset, aborts any frame
//   start      : request a full 32-bit frame (wins over repeat_req)
//   repeat_req : request a repeat code
//   command    : payload, sent LSB first, latched on acceptance
//   busy       : high from the cycle after acceptance until the gap ends
//   done       : one-cycle pulse when the gap ends
//   ir_env     : mark envelope (1 = mark)
//   ir_led     : envelope gated by the carrier, drives the LED
module ir_encoder
  import ir_pkg::*;
#(
  parameter int unsigned clk_hz     = 25000000,
  parameter int unsigned carrier_hz = 38000,
  parameter int unsigned gap_units  = 72
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        repeat_req,
  input  logic [31:0] command,
  output logic        busy,
  output logic        done,
  output logic        ir_env,
  output logic        ir_led
);

  localparam int unsigned UNIT_CYCLES = unit_cycles_f(clk_hz);
  localparam int unsigned HALF_CYCLES = clk_hz / (2 * carrier_hz);
  localparam int unsigned MAX_UNITS   = (gap_units > LEAD_MARK_UNITS) ? gap_units : LEAD_MARK_UNITS;
  localparam int unsigned CYC_W       = (UNIT_CYCLES > 1) ? $clog2(UNIT_CYCLES) : 1;
  localparam int unsigned UNIT_W      = (MAX_UNITS > 1) ? $clog2(MAX_UNITS) : 1;
  localparam int unsigned IDX_W       = $clog2(NEC_BITS);

  ir_state_t          state;
  logic [CYC_W-1:0]   cyc_cnt;
  logic [UNIT_W-1:0]  unit_cnt;
  logic [IDX_W-1:0]   bit_idx;
  logic [31:0]        cmd_q;
  logic               is_rep;

  logic [UNIT_W-1:0]  last_unit;
  logic               unit_last;
  logic               state_done;
  logic               request;
  logic               enter_mark;
  logic               carrier;

  assign request    = start | repeat_req;
  assign unit_last  = (cyc_cnt == CYC_W'(UNIT_CYCLES - 1));
  assign state_done = unit_last && (unit_cnt == last_unit);

  // Index of the final unit of the current state
  always_comb begin
    last_unit = '0;
    case (state)
      LEAD_MARK:  last_unit = UNIT_W'(LEAD_MARK_UNITS - 1);
      LEAD_SPACE: last_unit = is_rep ? UNIT_W'(REPEAT_SPACE_UNITS - 1)
                                     : UNIT_W'(LEAD_SPACE_UNITS - 1);
      BIT_SPACE:  last_unit = cmd_q[bit_idx] ? UNIT_W'(ONE_SPACE_UNITS - 1)
                                             : UNIT_W'(SHORT_UNITS - 1);
      GAP:        last_unit = UNIT_W'(gap_units - 1);
      default:    last_unit = UNIT_W'(SHORT_UNITS - 1);
    endcase
  end

  // Every path into a mark state passes through one of these transitions;
  // restarting the carrier here makes it high on the first mark cycle.
  always_comb begin
    enter_mark = 1'b0;
    case (state)
      IDLE:                  enter_mark = request;
      LEAD_SPACE, BIT_SPACE: enter_mark = state_done;
      default:               enter_mark = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cyc_cnt  <= '0;
      unit_cnt <= '0;
      bit_idx  <= '0;
      cmd_q    <= '0;
      is_rep   <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      ir_env   <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state == IDLE) begin
        if (request) begin
          cmd_q    <= command;
          is_rep   <= ~start;
          state    <= LEAD_MARK;
          busy     <= 1'b1;
          ir_env   <= 1'b1;
          cyc_cnt  <= '0;
          unit_cnt <= '0;
          bit_idx  <= '0;
        end
      end else if (state_done) begin
        cyc_cnt  <= '0;
        unit_cnt <= '0;
        case (state)
          LEAD_MARK: begin
            state  <= LEAD_SPACE;
            ir_env <= 1'b0;
          end
          LEAD_SPACE: begin
            state  <= is_rep ? STOP_MARK : BIT_MARK;
            ir_env <= 1'b1;
          end
          BIT_MARK: begin
            state  <= BIT_SPACE;
            ir_env <= 1'b0;
          end
          BIT_SPACE: begin
            bit_idx <= bit_idx + 1'b1;
            state   <= (bit_idx == IDX_W'(NEC_BITS - 1)) ? STOP_MARK : BIT_MARK;
            ir_env  <= 1'b1;
          end
          STOP_MARK: begin
            state  <= GAP;
            ir_env <= 1'b0;
          end
          GAP: begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
          default: begin
            state  <= IDLE;
            busy   <= 1'b0;
            ir_env <= 1'b0;
          end
        endcase
      end else if (unit_last) begin
        cyc_cnt  <= '0;
        unit_cnt <= unit_cnt + 1'b1;
      end else begin
        cyc_cnt <= cyc_cnt + 1'b1;
      end
    end
  end

  ir_carrier #(
    .half_cycles(HALF_CYCLES)
  ) u_carrier (
    .clk     (clk),
    .rst     (rst),
    .restart (enter_mark),
    .carrier (carrier)
  );

  assign ir_led = ir_env & carrier;

endmodule
